vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-clock arbiter that shares the single-port pixel RAM between the VGA pixel fetch path and the CPU data port. The VGA path has priority so scan-out never tears. A starvation counter guarantees the CPU a slot within a bounded number of cycles, and a one-entry buffer absorbs the VGA fetch displaced by that forced CPU grant. It sits between the CPU memory interface, the VGA pixel generator and the synchronous-read RAM.

## Interface
- ADDR_W, 16, RAM word address width
- DATA_W, 32, RAM data width
- STARVE_MAX, 8, cycles a waiting CPU request may lose before it is force-granted (1..255)
- clk  in  1  system clock; the only clock in the block
- rst  in  1  synchronous reset, active-high
- vga_req  in  1  single-cycle fetch strobe from the pixel path; not held
- vga_addr  in  ADDR_W  fetch address, valid with vga_req
- vga_rdata  out  DATA_W  registered fetch data
- vga_rvalid  out  1  one-cycle pulse; vga_rdata is valid
- vga_ovf  out  1  sticky; a VGA fetch was dropped
- cpu_req  in  1  CPU request; held with addr/we/wdata stable until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  registered read data; held until the next CPU read completes
- cpu_ready  out  1  one-cycle completion pulse for reads and writes
- ram_addr  out  ADDR_W  RAM address (combinational from the grant)
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after the address is sampled

## Operation
- One grant per cycle, chosen among three sources: VGA buffer entry (vbuf), live vga_req, and the CPU. RAM signals are driven combinationally from the winner.
- Priority order:
  1. CPU, when the CPU FSM is in WAIT and starve_cnt == STARVE_MAX.
  2. vbuf.
  3. Live vga_req.
  4. CPU in WAIT.
- A live vga_req that loses to a forced CPU grant or to vbuf is written into vbuf.
  - If vbuf is occupied and is not being drained in that cycle, the request is dropped and vga_ovf is set.
  - If the live vga_req loses to vbuf itself, it replaces vbuf; no drop.
- CPU FSM:
  - IDLE → WAIT when cpu_req = 1.
  - WAIT → ISSUED on grant.
  - ISSUED → DONE unconditionally.
  - DONE → IDLE unconditionally. cpu_ready is asserted in DONE.
  - cpu_req is ignored in ISSUED and DONE. A request still high in IDLE after DONE is a new transaction.
- starve_cnt (8 bits):
  - Increments each WAIT cycle in which the CPU is not granted; saturates at STARVE_MAX.
  - Clears on CPU grant and in IDLE.
- Read tag pipeline: a 2-stage owner tag (none/VGA/CPU) follows each grant. At stage 2, ram_rdata is registered into vga_rdata or cpu_rdata, with the matching valid/ready pulse.
- CPU writes:
  - ram_we = 1 only in the grant cycle.
  - cpu_rdata is unchanged.
  - cpu_ready timing matches reads.
- ram_we is 0 in every cycle that is not a CPU write grant, and whenever rst = 1.

## Timing
- Grant in cycle N:
  - RAM samples the address at the end of N.
  - ram_rdata is valid in N+1 and is registered at the end of N+1.
  - vga_rvalid / cpu_ready is high in N+2, with data on the registered output in N+2.
- Unblocked VGA: vga_req in N → vga_rvalid in N+2.
- Buffered VGA: vga_req in N → vga_rvalid in N+3.
- Uncontended CPU:
  - cpu_req rises in N → FSM enters WAIT in N+1 → grant in N+1 → cpu_ready in N+3.
  - Next grant possible in N+5.
- Worst-case CPU wait under continuous vga_req: STARVE_MAX losing cycles, then a forced grant.
- Reset values: all outputs 0, including vga_rdata, cpu_rdata and ram_addr. FSM = IDLE, starve_cnt = 0, vbuf empty, tag pipeline empty.
- Reset mid-operation:
  - In-flight tags are discarded; no rvalid/ready pulse follows.
  - A write granted in the reset cycle is suppressed.
  - vga_ovf is cleared only by rst.

## Test plan
- After reset, vga_req with addr 0x0010 and RAM word 0xA5A5A5A5 → vga_rvalid exactly 2 cycles later, vga_rdata = 0xA5A5A5A5. No cpu_ready.
- CPU write of 0x12345678 to 0x0100, then a read of 0x0100, no VGA traffic:
  - ram_we is high for exactly 1 cycle.
  - The write's cpu_ready comes 3 cycles after cpu_req rises.
  - The read returns cpu_rdata = 0x12345678.
- vga_req every cycle with a CPU read pending, STARVE_MAX = 8:
  - The CPU is granted after exactly 8 losing cycles.
  - The displaced VGA fetch arrives 1 cycle late.
  - No VGA fetch is lost; vga_ovf = 0.
- Forced CPU grant while vbuf is already full (vbuf preloaded, then live vga_req in the forced-grant cycle) → vga_ovf = 1, held until rst.
- rst asserted in the cycle after a CPU read grant → no cpu_ready, all outputs 0 on the next cycle. A subsequent read completes normally.
- Simultaneous vga_req and cpu_req rise with starve_cnt = 0 → VGA granted first; the CPU follows on the first idle VGA cycle.

Source files
------------

// File: rtl/vram_arbiter.sv
// Shares one synchronous-read pixel RAM between the VGA fetch path and the CPU.
// VGA wins by default; a starvation counter forces a CPU slot and a one-entry buffer holds the displaced fetch.
module vram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    output logic              vga_ovf,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        CPU_IDLE   = 2'd0,
        CPU_WAIT   = 2'd1,
        CPU_ISSUED = 2'd2,
        CPU_DONE   = 2'd3
    } cpu_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_CPU  = 2'd2
    } tag_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    cpu_state_t        cpu_state_q, cpu_state_d;
    logic [7:0]        starve_cnt_q, starve_cnt_d;
    logic              vbuf_valid_q, vbuf_valid_d;
    logic [ADDR_W-1:0] vbuf_addr_q, vbuf_addr_d;
    tag_t              tag_q, tag_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic              vga_rvalid_q, vga_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              vga_ovf_q, vga_ovf_d;

    logic cpu_wait;
    logic cpu_force;
    logic grant_cpu;
    logic grant_vbuf;
    logic grant_live;
    logic vga_drop;

    // Grant selection; nothing is granted while reset is held so no write can slip through.
    always_comb begin
        cpu_wait   = (cpu_state_q == CPU_WAIT);
        cpu_force  = cpu_wait && (starve_cnt_q == STARVE_LIM);
        grant_cpu  = 1'b0;
        grant_vbuf = 1'b0;
        grant_live = 1'b0;
        vga_drop   = 1'b0;
        if (!rst) begin
            if (cpu_force) begin
                grant_cpu = 1'b1;
                vga_drop  = vga_req && vbuf_valid_q;
            end else if (vbuf_valid_q) begin
                grant_vbuf = 1'b1;
            end else if (vga_req) begin
                grant_live = 1'b1;
            end else if (cpu_wait) begin
                grant_cpu = 1'b1;
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (grant_cpu) begin
            ram_addr = cpu_addr;
            ram_we   = cpu_we;
            if (cpu_we) begin
                ram_wdata = cpu_wdata;
            end
        end else if (grant_vbuf) begin
            ram_addr = vbuf_addr_q;
        end else if (grant_live) begin
            ram_addr = vga_addr;
        end
    end

    // A live fetch that loses either takes over the buffer slot or, if the slot is stuck, is dropped.
    always_comb begin
        vbuf_valid_d = vbuf_valid_q;
        vbuf_addr_d  = vbuf_addr_q;
        vga_ovf_d    = vga_ovf_q | vga_drop;
        if (grant_vbuf) begin
            vbuf_valid_d = vga_req;
            if (vga_req) begin
                vbuf_addr_d = vga_addr;
            end
        end else if (cpu_force && vga_req && !vbuf_valid_q && !rst) begin
            vbuf_valid_d = 1'b1;
            vbuf_addr_d  = vga_addr;
        end
    end

    always_comb begin
        tag_d = TAG_NONE;
        if (grant_vbuf || grant_live) begin
            tag_d = TAG_VGA;
        end else if (grant_cpu && !cpu_we) begin
            tag_d = TAG_CPU;
        end
        vga_rvalid_d = (tag_q == TAG_VGA);
        vga_rdata_d  = (tag_q == TAG_VGA) ? ram_rdata : vga_rdata_q;
        cpu_rdata_d  = (tag_q == TAG_CPU) ? ram_rdata : cpu_rdata_q;
    end

    always_comb begin
        cpu_state_d = cpu_state_q;
        case (cpu_state_q)
            CPU_IDLE:   if (cpu_req) cpu_state_d = CPU_WAIT;
            CPU_WAIT:   if (grant_cpu) cpu_state_d = CPU_ISSUED;
            CPU_ISSUED: cpu_state_d = CPU_DONE;
            CPU_DONE:   cpu_state_d = CPU_IDLE;
            default:    cpu_state_d = CPU_IDLE;
        endcase
    end

    always_comb begin
        starve_cnt_d = 8'd0;
        if (cpu_wait && !grant_cpu) begin
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_state_q  <= CPU_IDLE;
            starve_cnt_q <= 8'd0;
            vbuf_valid_q <= 1'b0;
            vbuf_addr_q  <= '0;
            tag_q        <= TAG_NONE;
            vga_rdata_q  <= '0;
            vga_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            vga_ovf_q    <= 1'b0;
        end else begin
            cpu_state_q  <= cpu_state_d;
            starve_cnt_q <= starve_cnt_d;
            vbuf_valid_q <= vbuf_valid_d;
            vbuf_addr_q  <= vbuf_addr_d;
            tag_q        <= tag_d;
            vga_rdata_q  <= vga_rdata_d;
            vga_rvalid_q <= vga_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vga_ovf_q    <= vga_ovf_d;
        end
    end

    assign vga_rdata  = vga_rdata_q;
    assign vga_rvalid = vga_rvalid_q;
    assign vga_ovf    = vga_ovf_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ready  = (cpu_state_q == CPU_DONE);

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a RAM model plus a rule-level reference of who owns each RAM slot.
module tb_vram_arbiter;
    localparam int SM = 8;

    typedef struct {
        int          t;
        logic [31:0] d;
        logic        we;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic [31:0] vga_rdata;
    logic        vga_rvalid;
    logic        vga_ovf;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    vram_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata),
        .vga_rvalid(vga_rvalid), .vga_ovf(vga_ovf),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hA5A5A5A5;
        return 32'h5A000000 ^ (i * 32'h00010203);
    endfunction

    logic        mem_load;
    logic [31:0] mem [0:511];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
        end else if (ram_we) begin
            mem[ram_addr[8:0]] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr[8:0]];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference state
    logic [31:0] shadow [0:511];
    exp_t        vq[$];
    exp_t        cq[$];
    bit          m_wait = 0;
    int          m_lost = 0;
    int          m_idle_at = 0;
    bit          m_buf = 0;
    logic [15:0] m_buf_addr = '0;
    bit          m_ovf = 0;
    logic [31:0] m_cpu_rdata = '0;

    // observation records
    int n_vga_req = 0;
    int n_vga_rv = 0;
    int n_cpu_ready = 0;
    int n_we = 0;
    int last_vga_rv_cyc = -1;
    logic [31:0] last_vga_rv_data = '0;
    int last_cpu_ready_cyc = -1;
    bit rv_at [int];

    task automatic step(input logic r, input logic vreq, input logic [15:0] vaddr,
                        input logic cstart, input logic cwe, input logic [15:0] caddr,
                        input logic [31:0] cwd);
        exp_t e;
        bit ev, ec, fz, gc, sv, e_we;
        logic [15:0] sa, ea;
        @(negedge clk);
        ev = (vq.size() > 0) && (vq[0].t == cyc);
        ec = (cq.size() > 0) && (cq[0].t == cyc);
        rv_at[cyc] = vga_rvalid;
        if (vga_rvalid === 1'b1) begin
            n_vga_rv++; last_vga_rv_cyc = cyc; last_vga_rv_data = vga_rdata;
        end
        if (cpu_ready === 1'b1) begin
            n_cpu_ready++; last_cpu_ready_cyc = cyc;
        end
        checks++;
        if (vga_rvalid !== ev) begin
            errors++; $display("FAIL vga_rvalid cyc=%0d got=%b exp=%b", cyc, vga_rvalid, ev);
        end
        if (ev) begin
            e = vq.pop_front();
            checks++;
            if (vga_rdata !== e.d) begin
                errors++; $display("FAIL vga_rdata cyc=%0d got=%h exp=%h", cyc, vga_rdata, e.d);
            end
        end
        checks++;
        if (cpu_ready !== ec) begin
            errors++; $display("FAIL cpu_ready cyc=%0d got=%b exp=%b", cyc, cpu_ready, ec);
        end
        if (ec) begin
            e = cq.pop_front();
            if (!e.we) m_cpu_rdata = e.d;
        end
        checks++;
        if (cpu_rdata !== m_cpu_rdata) begin
            errors++; $display("FAIL cpu_rdata cyc=%0d got=%h exp=%h", cyc, cpu_rdata, m_cpu_rdata);
        end
        checks++;
        if (vga_ovf !== m_ovf) begin
            errors++; $display("FAIL vga_ovf cyc=%0d got=%b exp=%b", cyc, vga_ovf, m_ovf);
        end

        rst = r; vga_req = vreq; vga_addr = vaddr;
        if (ec) cpu_req = 1'b0;
        if (cstart && !cpu_req) begin
            cpu_req = 1'b1; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        end
        if (vreq && !r) n_vga_req++;
        #1;

        ea = '0; e_we = 0;
        if (r) begin
            m_wait = 0; m_lost = 0; m_idle_at = cyc + 1; m_buf = 0;
            m_ovf = 0; m_cpu_rdata = '0;
            vq.delete(); cq.delete();
        end else begin
            fz = m_wait && (m_lost == SM);
            gc = 0; sv = 0; sa = '0;
            if (fz) begin
                gc = 1;
                if (vreq) begin
                    if (m_buf) m_ovf = 1;
                    else begin m_buf = 1; m_buf_addr = vaddr; end
                end
            end else if (m_buf) begin
                sv = 1; sa = m_buf_addr;
                if (vreq) m_buf_addr = vaddr; else m_buf = 0;
                if (m_wait) m_lost++;
            end else if (vreq) begin
                sv = 1; sa = vaddr;
                if (m_wait) m_lost++;
            end else if (m_wait) begin
                gc = 1;
            end
            if (sv) begin
                ea = sa; e.t = cyc + 2; e.d = shadow[sa[8:0]]; e.we = 0;
                vq.push_back(e);
            end
            if (gc) begin
                ea = cpu_addr; e.t = cyc + 2; e.we = cpu_we; e.d = shadow[cpu_addr[8:0]];
                cq.push_back(e);
                if (cpu_we) begin
                    e_we = 1; shadow[cpu_addr[8:0]] = cpu_wdata;
                end
                m_wait = 0; m_lost = 0; m_idle_at = cyc + 3;
            end else if (!m_wait && cyc >= m_idle_at && cpu_req) begin
                m_wait = 1; m_lost = 0;
            end
        end
        if (ram_we === 1'b1) n_we++;
        checks++;
        if (ram_we !== e_we) begin
            errors++; $display("FAIL ram_we cyc=%0d got=%b exp=%b", cyc, ram_we, e_we);
        end
        checks++;
        if (ram_addr !== ea) begin
            errors++; $display("FAIL ram_addr cyc=%0d got=%h exp=%h", cyc, ram_addr, ea);
        end
        if (e_we) begin
            checks++;
            if (ram_wdata !== cpu_wdata) begin
                errors++; $display("FAIL ram_wdata cyc=%0d got=%h exp=%h", cyc, ram_wdata, cpu_wdata);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_reset;
        step(1, 0, '0, 0, 0, '0, '0);
        mem_load = 1'b0;
        step(1, 0, '0, 0, 0, '0, '0);
        step(1, 0, '0, 0, 0, '0, '0);
        @(posedge clk); #1;
        checks++;
        if ({vga_rvalid, vga_ovf, cpu_ready, ram_we} !== 4'b0 || vga_rdata !== '0 ||
            cpu_rdata !== '0 || ram_addr !== '0 || ram_wdata !== '0) begin
            errors++;
            $display("FAIL reset_state got flags=%b vga_rdata=%h cpu_rdata=%h ram_addr=%h exp all zero",
                     {vga_rvalid, vga_ovf, cpu_ready, ram_we}, vga_rdata, cpu_rdata, ram_addr);
        end
        $display("test_reset done cyc=%0d", cyc);
    endtask

    task automatic test_vga_basic;
        int c0, rc;
        c0 = cyc; rc = n_cpu_ready;
        step(0, 1, 16'h0010, 0, 0, '0, '0);
        idle(4);
        checks++;
        if (last_vga_rv_cyc !== c0 + 2) begin
            errors++; $display("FAIL vga_latency got=%0d exp=%0d", last_vga_rv_cyc - c0, 2);
        end
        checks++;
        if (last_vga_rv_data !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL vga_basic_data got=%h exp=a5a5a5a5", last_vga_rv_data);
        end
        checks++;
        if (n_cpu_ready !== rc) begin
            errors++; $display("FAIL vga_basic_no_ready got=%0d exp=%0d", n_cpu_ready - rc, 0);
        end
        $display("test_vga_basic done data=%h", last_vga_rv_data);
    endtask

    task automatic test_cpu_write_read;
        int c0, w0;
        c0 = cyc; w0 = n_we;
        step(0, 0, '0, 1, 1, 16'h0100, 32'h12345678);
        idle(5);
        checks++;
        if (n_we - w0 !== 1) begin
            errors++; $display("FAIL write_we_cycles got=%0d exp=1", n_we - w0);
        end
        checks++;
        if (last_cpu_ready_cyc !== c0 + 3) begin
            errors++; $display("FAIL write_ready_latency got=%0d exp=3", last_cpu_ready_cyc - c0);
        end
        step(0, 0, '0, 1, 0, 16'h0100, '0);
        idle(5);
        checks++;
        if (cpu_rdata !== 32'h12345678) begin
            errors++; $display("FAIL read_back got=%h exp=12345678", cpu_rdata);
        end
        $display("test_cpu_write_read done rdata=%h", cpu_rdata);
    endtask

    task automatic test_starvation;
        int c0, rv0, rq0;
        c0 = cyc; rv0 = n_vga_rv; rq0 = n_vga_req;
        step(0, 1, 16'h0000, 1, 0, 16'h0020, '0);
        for (int k = 1; k < 15; k++) step(0, 1, 16'(k), 0, 0, '0, '0);
        idle(6);
        checks++;
        if (last_cpu_ready_cyc !== c0 + 11) begin
            errors++; $display("FAIL starve_ready got=%0d exp=11", last_cpu_ready_cyc - c0);
        end
        checks++;
        if (rv_at[c0 + 10] !== 1'b1 || rv_at[c0 + 11] !== 1'b0 || rv_at[c0 + 12] !== 1'b1) begin
            errors++;
            $display("FAIL starve_displaced got=%b%b%b exp=101", rv_at[c0 + 10], rv_at[c0 + 11], rv_at[c0 + 12]);
        end
        checks++;
        if ((n_vga_rv - rv0) !== (n_vga_req - rq0) || vga_ovf !== 1'b0) begin
            errors++;
            $display("FAIL starve_no_loss got=%0d/%0d ovf=%b exp equal, ovf=0", n_vga_rv - rv0, n_vga_req - rq0, vga_ovf);
        end
        $display("test_starvation done ready_at=+%0d", last_cpu_ready_cyc - c0);
    endtask

    task automatic test_overflow;
        int rv0, rq0;
        rv0 = n_vga_rv; rq0 = n_vga_req;
        for (int k = 0; k < 30; k++) step(0, 1, 16'(k + 32), (k < 12), 0, 16'(k), '0);
        idle(6);
        checks++;
        if (vga_ovf !== 1'b1 || (n_vga_req - rq0) - (n_vga_rv - rv0) !== 1) begin
            errors++;
            $display("FAIL overflow got ovf=%b lost=%0d exp ovf=1 lost=1", vga_ovf, (n_vga_req - rq0) - (n_vga_rv - rv0));
        end
        idle(10);
        checks++;
        if (vga_ovf !== 1'b1) begin
            errors++; $display("FAIL overflow_sticky got=%b exp=1", vga_ovf);
        end
        step(1, 0, '0, 0, 0, '0, '0);
        idle(1);
        checks++;
        if (vga_ovf !== 1'b0) begin
            errors++; $display("FAIL overflow_clear got=%b exp=0", vga_ovf);
        end
        $display("test_overflow done");
    endtask

    task automatic test_reset_midop;
        int rc;
        idle(2);
        rc = n_cpu_ready;
        step(0, 0, '0, 1, 0, 16'h0030, '0);
        idle(1);
        step(1, 0, '0, 0, 0, '0, '0);
        @(posedge clk); #1;
        checks++;
        if ({vga_rvalid, vga_ovf, cpu_ready, ram_we} !== 4'b0 || vga_rdata !== '0 ||
            cpu_rdata !== '0 || ram_addr !== '0) begin
            errors++;
            $display("FAIL midop_zero got flags=%b vga_rdata=%h cpu_rdata=%h ram_addr=%h exp all zero",
                     {vga_rvalid, vga_ovf, cpu_ready, ram_we}, vga_rdata, cpu_rdata, ram_addr);
        end
        idle(2);
        checks++;
        if (n_cpu_ready !== rc) begin
            errors++; $display("FAIL midop_no_ready got=%0d exp=0", n_cpu_ready - rc);
        end
        idle(4);
        checks++;
        if (n_cpu_ready !== rc + 1 || cpu_rdata !== init_word(16'h0030)) begin
            errors++;
            $display("FAIL midop_retry got ready=%0d data=%h exp ready=1 data=%h", n_cpu_ready - rc, cpu_rdata, init_word(16'h0030));
        end
        $display("test_reset_midop done");
    endtask

    task automatic test_simultaneous;
        int c0;
        c0 = cyc;
        step(0, 1, 16'h0011, 1, 0, 16'h0012, '0);
        step(0, 1, 16'h0013, 0, 0, '0, '0);
        step(0, 1, 16'h0014, 0, 0, '0, '0);
        idle(6);
        checks++;
        if (rv_at[c0 + 2] !== 1'b1 || last_cpu_ready_cyc !== c0 + 5) begin
            errors++;
            $display("FAIL simultaneous got vga@2=%b ready@%0d exp vga@2=1 ready@5", rv_at[c0 + 2], last_cpu_ready_cyc - c0);
        end
        checks++;
        if (cpu_rdata !== init_word(16'h0012)) begin
            errors++; $display("FAIL simultaneous_data got=%h exp=%h", cpu_rdata, init_word(16'h0012));
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_random;
        int prob;
        for (int i = 0; i < 3000; i++) begin
            case ((i / 200) % 4)
                0: prob = 30;
                1: prob = 60;
                2: prob = 95;
                default: prob = 100;
            endcase
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 99) < prob), 16'($urandom_range(0, 31)),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 31)), $urandom);
        end
        idle(6);
        $display("test_random done cyc=%0d", cyc);
    endtask

    initial begin
        rst = 1'b1; vga_req = 1'b0; vga_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_load = 1'b1;
        for (int i = 0; i < 512; i++) shadow[i] = init_word(i);
        test_reset;
        test_vga_basic;
        test_cpu_write_read;
        test_starvation;
        test_overflow;
        test_reset_midop;
        test_simultaneous;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
